// File: rtl/paddle_renderer_if.sv
// Pixel-write bus between the paddle renderer and its controller / VGA adapter.
// The renderer sits on the slave side; the game controller and adapter sit on the master side.
interface paddle_renderer_if;
   logic       start;
   logic [6:0] yPaddleCoord;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport slave (
      input  start, yPaddleCoord,
      output x, y, colour, plot, busy, done
   );

   modport master (
      output start, yPaddleCoord,
      input  x, y, colour, plot, busy, done
   );
endinterface

// File: rtl/paddle_renderer.sv
// Paddle renderer: erases the previously drawn paddle rectangle, then draws it at the
// newly requested row, one pixel write per cycle to a 160x120 VGA adapter.
module paddle_renderer #(
   parameter logic [7:0] X_POS         = 8'd4,
   parameter int         PADDLE_W      = 2,
   parameter int         PADDLE_H      = 8,
   parameter logic [2:0] PADDLE_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [6:0] Y_MAX         = 7'd119
) (
   input  logic              clock,
   input  logic              resetn,   // active-high synchronous reset
   paddle_renderer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t     state, state_next;
   logic [2:0] col, col_next;
   logic [3:0] row, row_next;
   logic [6:0] new_y, new_y_next;
   logic [6:0] old_y, old_y_next;
   logic       drawn_valid, drawn_valid_next;

   logic [7:0] x_q, x_next;
   logic [6:0] y_q, y_next;
   logic [2:0] colour_q, colour_next;
   logic       plot_q, plot_next;
   logic       busy_q, busy_next;
   logic       done_q, done_next;

   logic [6:0] base;
   logic [7:0] row_sum;
   logic       last_col;
   logic       last_pix;

   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.colour = colour_q;
   assign bus.plot   = plot_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

   // State, scan counters and registered adapter outputs.
   always_ff @(posedge clock) begin
      if (resetn) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         new_y       <= '0;
         old_y       <= '0;
         drawn_valid <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         colour_q    <= '0;
         plot_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_next;
         col         <= col_next;
         row         <= row_next;
         new_y       <= new_y_next;
         old_y       <= old_y_next;
         drawn_valid <= drawn_valid_next;
         x_q         <= x_next;
         y_q         <= y_next;
         colour_q    <= colour_next;
         plot_q      <= plot_next;
         busy_q      <= busy_next;
         done_q      <= done_next;
      end
   end

   // Next-state and next-output logic; one rectangle pixel per cycle in ERASE/DRAW.
   always_comb begin
      state_next       = state;
      col_next         = col;
      row_next         = row;
      new_y_next       = new_y;
      old_y_next       = old_y;
      drawn_valid_next = drawn_valid;
      x_next           = x_q;
      y_next           = y_q;
      colour_next      = colour_q;
      plot_next        = 1'b0;
      busy_next        = busy_q;
      done_next        = 1'b0;

      // Row sum kept 8 bits wide so rows past 127 are clipped rather than wrapping to the top.
      base     = (state == ERASE) ? old_y : new_y;
      row_sum  = {1'b0, base} + {4'b0000, row};
      last_col = (col == 3'(PADDLE_W - 1));
      last_pix = last_col && (row == 4'(PADDLE_H - 1));

      case (state)
         IDLE: begin
            if (bus.start) begin
               new_y_next = bus.yPaddleCoord;
               busy_next  = 1'b1;
               col_next   = '0;
               row_next   = '0;
               state_next = drawn_valid ? ERASE : DRAW;
            end
         end
         ERASE, DRAW: begin
            x_next      = X_POS + {5'b00000, col};
            y_next      = row_sum[6:0];
            colour_next = (state == ERASE) ? BG_COLOUR : PADDLE_COLOUR;
            plot_next   = (row_sum <= {1'b0, Y_MAX});
            if (last_pix) begin
               col_next   = '0;
               row_next   = '0;
               state_next = (state == ERASE) ? DRAW : DONE;
            end else if (last_col) begin
               col_next = '0;
               row_next = row + 4'd1;
            end else begin
               col_next = col + 3'd1;
            end
         end
         DONE: begin
            done_next        = 1'b1;
            busy_next        = 1'b0;
            old_y_next       = new_y;
            drawn_valid_next = 1'b1;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_paddle_renderer.sv
// Directed bench for paddle_renderer: render sequences with hand-derived pixel streams.
module tb_paddle_renderer;
   localparam int W = 2;
   localparam int H = 8;
   localparam int N = W * H;

   logic clock  = 1'b0;
   logic resetn = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clock = ~clock;

   paddle_renderer_if bus();

   paddle_renderer #(
      .X_POS(8'd4),
      .PADDLE_W(2),
      .PADDLE_H(8),
      .PADDLE_COLOUR(3'b111),
      .BG_COLOUR(3'b000),
      .Y_MAX(7'd119)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_x"}, bus.x, 0);
      check({tag, "_y"}, bus.y, 0);
      check({tag, "_colour"}, bus.colour, 0);
      check({tag, "_plot"}, bus.plot, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
   endtask

   // Start a render at ny (cycle 0) and check every cycle up to one past done.
   // s1/s2: cycles at which an extra start is sampled (0 = none).
   task automatic render(input int ny, input bit erase, input int oy, input int s1, input int s2);
      int total, idx, r, c, base, rowv, plots, exp_plots;
      bit er;
      total = erase ? 2 * N : N;
      plots = 0;
      exp_plots = 0;
      bus.yPaddleCoord = 7'(ny);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("c0_busy", bus.busy, 1);
      check("c0_plot", bus.plot, 0);
      check("c0_done", bus.done, 0);
      for (int k = 1; k <= total + 1; k++) begin
         bus.start = (k == s1) || (k == s2);
         bus.yPaddleCoord = 7'($urandom_range(0, 127));
         tick();
         if (k <= total) begin
            er   = erase && (k <= N);
            idx  = (erase && !er) ? (k - 1 - N) : (k - 1);
            r    = idx / W;
            c    = idx % W;
            base = er ? oy : ny;
            rowv = base + r;
            check("px_plot", bus.plot, (rowv <= 119) ? 1 : 0);
            check("px_x", bus.x, 4 + c);
            check("px_y", bus.y, rowv & 127);
            check("px_colour", bus.colour, er ? 0 : 7);
            check("px_busy", bus.busy, 1);
            check("px_done", bus.done, 0);
            if (bus.plot) plots++;
            if (rowv <= 119) exp_plots++;
         end else begin
            check("done_pulse", bus.done, 1);
            check("done_busy", bus.busy, 0);
            check("done_plot", bus.plot, 0);
            check("done_x_hold", bus.x, 4 + W - 1);
            check("done_y_hold", bus.y, (ny + H - 1) & 127);
            check("done_colour_hold", bus.colour, 7);
         end
      end
      bus.start = 1'b0;
      tick();
      check("post_done", bus.done, 0);
      check("post_busy", bus.busy, 0);
      check("post_plot", bus.plot, 0);
      check("plot_count", plots, exp_plots);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.yPaddleCoord = '0;

      // Reset, then idle with everything at reset values.
      resetn = 1'b1;
      tick();
      tick();
      resetn = 1'b0;
      check_reset_outputs("reset");
      for (int i = 0; i < 10; i++) begin
         tick();
         check_reset_outputs("idle");
      end

      // First render (draw only), then erase+draw, clipped render, same-row rerender.
      render(56, 1'b0, 0, 0, 0);
      render(64, 1'b1, 56, 0, 0);
      render(116, 1'b1, 64, 0, 0);
      render(116, 1'b1, 116, 0, 0);

      // Starts while busy (cycle 3) and during done (cycle 17) are ignored.
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      tick();
      render(56, 1'b0, 0, 3, 17);

      // Reset mid-erase at cycle 5 aborts; next render has no erase phase.
      bus.yPaddleCoord = 7'd20;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("abort_erase_plot", bus.plot, 1);
         check("abort_erase_colour", bus.colour, 0);
         check("abort_erase_y", bus.y, 56 + (k - 1) / W);
      end
      resetn = 1'b1;
      tick();
      check_reset_outputs("abort");
      resetn = 1'b0;
      tick();
      check_reset_outputs("abort_idle");
      render(0, 1'b0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
